// File: rtl/tc_serial_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tc_serial_collector_pkg
// Purpose : Shared definitions for the serial word collector: default word
//           width, FSM state encoding and the counter-width helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package tc_serial_collector_pkg;

  localparam int TC_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,   // waiting for a start-of-word marker
    ST_RECV = 1'b1    // collecting bits 1..WIDTH-1
  } tc_state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_serial_collector_if.sv
`default_nettype none
// ============================================================================
// Module  : tc_serial_collector_if
// Purpose : Bundles the serial input pair and the parallel valid/ready output
//           of the collector.
// Ports   : sin/sstart   serial bit and start-of-word marker
//           data_out     assembled word (bit i = i-th received bit)
//           valid/ready  parallel handshake
//           neg/zero     word flags, registered with data_out
//           overrun      sticky dropped-word flag
//           slave  modport: the collector
//           master modport: the stream source / parallel consumer
// Rev     : 1.0  initial release
// ============================================================================
interface tc_serial_collector_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sstart;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             ready;
  logic             neg;
  logic             zero;
  logic             overrun;

  modport slave (
    input  sin, sstart, ready,
    output data_out, valid, neg, zero, overrun
  );

  modport master (
    output sin, sstart, ready,
    input  data_out, valid, neg, zero, overrun
  );
endinterface
`default_nettype wire

// File: rtl/tc_serial_collector.sv
`default_nettype none
// ============================================================================
// Module  : tc_serial_collector
// Purpose : Assembles LSB-first serial words (marked by sstart on bit 0) into
//           WIDTH-bit parallel words offered with a valid/ready handshake.
//           A word that completes while the previous one is still unconsumed
//           is dropped and raises the sticky overrun flag.
// Ports   : clock    system clock, rising edge
//           reset_n  synchronous active-low reset
//           bus      tc_serial_collector_if.slave (serial in, parallel out)
// Rev     : 1.0  initial release
// ============================================================================
module tc_serial_collector
  import tc_serial_collector_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH
) (
  input  wire logic               clock,
  input  wire logic               reset_n,
  tc_serial_collector_if.slave    bus
);

  localparam int CW = clog2(WIDTH);

  tc_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_neg;
  logic             r_zero;
  logic             r_ovr;

  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_done;
  logic             w_unused_lsb;

  // New bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB,
  // so the shifted value on the final edge is the finished word.
  assign w_word       = {bus.sin, r_sh[WIDTH-1:1]};
  assign w_last       = (r_cnt == CW'(WIDTH - 1));
  // A start marker on the final bit restarts the word instead of completing it.
  assign w_done       = (r_state == ST_RECV) && !bus.sstart && w_last;
  // The LSB of the shift register is always shifted out before being used.
  assign w_unused_lsb = r_sh[0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b1;
      r_ovr   <= 1'b0;
    end else begin
      // Framing: sstart always (re)starts a word, discarding any partial one.
      if (bus.sstart) begin
        r_state <= ST_RECV;
        r_cnt   <= CW'(1);
        r_sh    <= {bus.sin, {(WIDTH-1){1'b0}}};
      end else if (r_state == ST_RECV) begin
        r_sh <= w_word;
        if (w_last) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      // Output register: load when the slot is free or being emptied now.
      if (w_done) begin
        if (!r_valid || bus.ready) begin
          r_data  <= w_word;
          r_neg   <= w_word[WIDTH-1];
          r_zero  <= (w_word == '0);
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;
  assign bus.neg      = r_neg;
  assign bus.zero     = r_zero;
  assign bus.overrun  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_tc_serial_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_tc_serial_collector
// Purpose : Self-checking bench for tc_serial_collector (WIDTH=8). Directed
//           scenarios followed by random traffic, all compared every cycle
//           against a bit-position reference model of the collector.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_tc_serial_collector;
  import tc_serial_collector_pkg::*;

  localparam int W = 8;

  logic clock;
  logic reset_n;

  tc_serial_collector_if #(.WIDTH(W)) bus ();

  tc_serial_collector #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position of the next expected bit (-1 = no word open),
  // the word built by placing each bit at its index, and the output slot.
  int         m_idx   = -1;
  logic [W-1:0] m_acc   = '0;
  logic [W-1:0] m_data  = '0;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;

  function automatic void model_edge(input logic rn, input logic s,
                                     input logic st, input logic rd);
    logic done;
    done = 1'b0;
    if (!rn) begin
      m_idx = -1; m_acc = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
      return;
    end
    if (st) begin
      m_acc    = '0;
      m_acc[0] = s;
      m_idx    = 1;
    end else if (m_idx >= 1) begin
      m_acc[m_idx] = s;
      m_idx++;
      if (m_idx == W) begin
        done  = 1'b1;
        m_idx = -1;
      end
    end
    if (done) begin
      if (!m_valid || rd) begin
        m_data  = m_acc;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic rn, input logic s, input logic st, input logic rd);
    reset_n    = rn;
    bus.sin    = s;
    bus.sstart = st;
    bus.ready  = rd;
    @(posedge clock);
    model_edge(rn, s, st, rd);
    #1;
    check("valid",    {31'd0, bus.valid},   {31'd0, m_valid});
    check("data_out", {24'd0, bus.data_out}, {24'd0, m_data});
    check("neg",      {31'd0, bus.neg},     {31'd0, m_data[W-1]});
    check("zero",     {31'd0, bus.zero},    {31'd0, (m_data == '0)});
    check("overrun",  {31'd0, bus.overrun}, {31'd0, m_ovr});
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rd);
    for (int i = 0; i < W; i++) step(1'b1, w[i], (i == 0), rd);
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.sin    = 1'b0;
    bus.sstart = 1'b0;
    bus.ready  = 1'b1;

    // 1: reset held with sstart/sin high
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t1_valid", {31'd0, bus.valid},    32'd0);
    check("t1_data",  {24'd0, bus.data_out}, 32'h00);
    check("t1_zero",  {31'd0, bus.zero},     32'd1);
    check("t1_ovr",   {31'd0, bus.overrun},  32'd0);

    // 2: single word 0xA5
    send_word(8'hA5, 1'b1);
    check("t2_data",  {24'd0, bus.data_out}, 32'hA5);
    check("t2_valid", {31'd0, bus.valid},    32'd1);
    check("t2_neg",   {31'd0, bus.neg},      32'd1);
    check("t2_zero",  {31'd0, bus.zero},     32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t2_drop",  {31'd0, bus.valid},    32'd0);

    // 3: back-to-back words
    send_word(8'h01, 1'b1);
    check("t3_w0",    {24'd0, bus.data_out}, 32'h01);
    check("t3_z0",    {31'd0, bus.zero},     32'd0);
    send_word(8'hFF, 1'b1);
    check("t3_w1",    {24'd0, bus.data_out}, 32'hFF);
    check("t3_n1",    {31'd0, bus.neg},      32'd1);
    send_word(8'h00, 1'b1);
    check("t3_w2",    {24'd0, bus.data_out}, 32'h00);
    check("t3_z2",    {31'd0, bus.zero},     32'd1);
    check("t3_v2",    {31'd0, bus.valid},    32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // 4: overrun with ready low
    send_word(8'h3C, 1'b0);
    check("t4_first", {24'd0, bus.data_out}, 32'h3C);
    send_word(8'h7E, 1'b0);
    check("t4_hold",  {24'd0, bus.data_out}, 32'h3C);
    check("t4_ovr",   {31'd0, bus.overrun},  32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_clr",   {31'd0, bus.valid},    32'd0);
    check("t4_stick", {31'd0, bus.overrun},  32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_stick2", {31'd0, bus.overrun}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_rst",   {31'd0, bus.overrun},  32'd0);

    // 5: resync after four bits
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_nopart", {31'd0, bus.valid},   32'd0);
    send_word(8'h81, 1'b1);
    check("t5_data",  {24'd0, bus.data_out}, 32'h81);
    check("t5_valid", {31'd0, bus.valid},    32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // 6: mid-word reset
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t6_stale", {31'd0, bus.valid},    32'd0);
    send_word(8'h55, 1'b1);
    check("t6_data",  {24'd0, bus.data_out}, 32'h55);
    check("t6_valid", {31'd0, bus.valid},    32'd1);
    check("t6_ovr",   {31'd0, bus.overrun},  32'd0);

    // Random framed words with random back-pressure
    for (int k = 0; k < 150; k++) begin
      send_word(W'($urandom), ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 3) == 0) step(1'b1, 1'($urandom), 1'b0, 1'($urandom));
    end

    // Random unframed traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) != 0), 1'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
